// File: rtl/key_pkg.sv
// Shared constants and types for the key-to-instruction front end.
package key_pkg;
    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] NOP             = '0;
    localparam logic [INSN_W-1:0] INSN_MOVE_LEFT  = 32'h2843FFE0;
    localparam logic [INSN_W-1:0] INSN_MOVE_RIGHT = 32'h28420020;

    // Output register contents: valid flag plus the instruction word.
    typedef struct packed {
        logic              valid;
        logic [INSN_W-1:0] insn;
    } insn_slot_t;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/key_debounce.sv
// One key channel: synchroniser, debouncer, press and auto-repeat event pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic key_n,
    input  logic repeat_en,
    output logic key_down,
    output logic key_event
);
    localparam int CW   = cnt_w(DEBOUNCE_CYCLES - 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_w(RMAX);
    localparam logic [CW-1:0] C_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

    logic [1:0]    sync;
    logic          pressed;
    logic          d;
    logic          d_q;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic          ph;
    logic          press;
    logic          fire;

    // Two-flop synchroniser; holds the pressed level so cleared flops read as released
    always_ff @(posedge clk_in) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], ~key_n};
    end

    assign pressed = sync[1];

    // Accept a level change only after it has persisted for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk_in) begin
        if (reset) begin
            d   <= 1'b0;
            d_q <= 1'b0;
            c   <= '0;
        end else begin
            d_q <= d;
            if (pressed == d) begin
                c <= '0;
            end else if (c == C_LAST) begin
                d <= ~d;
                c <= '0;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    // r counts cycles since the last event; ph marks that the first repeat has fired
    assign press = d & ~d_q;
    assign fire  = d & repeat_en & (ph ? (r == R_PERIOD) : (r == R_DELAY));

    // Repeat timer: idle at zero unless the key is held with repeat enabled
    always_ff @(posedge clk_in) begin
        if (reset || !(d && repeat_en)) begin
            r  <= '0;
            ph <= 1'b0;
        end else if (fire) begin
            r  <= RW'(1);
            ph <= 1'b1;
        end else begin
            r  <= r + 1'b1;
        end
    end

    assign key_down  = d;
    assign key_event = press | fire;
endmodule

// File: rtl/key_insn_injector.sv
// Key events to instruction words: per-key pending bits, priority pick, output register.
module key_insn_injector
    import key_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic [N_KEYS-1:0]        key_n,
    input  logic [INSN_W*N_KEYS-1:0] insn_table,
    input  logic [N_KEYS-1:0]        repeat_en,
    input  logic                     insn_ready,
    output logic [INSN_W-1:0]        insn_key,
    output logic                     insn_valid,
    output logic [N_KEYS-1:0]        key_down,
    output logic                     dropped
);
    logic [N_KEYS-1:0] ev;
    logic [N_KEYS-1:0] pend;
    logic [N_KEYS-1:0] clr;
    logic              load;
    logic              found;
    insn_slot_t        slot_q;
    insn_slot_t        slot_nxt;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_deb (
            .clk_in   (clk_in),
            .reset    (reset),
            .key_n    (key_n[g]),
            .repeat_en(repeat_en[g]),
            .key_down (key_down[g]),
            .key_event(ev[g])
        );
    end

    // The output register is free when empty or being drained this cycle
    assign load = ~slot_q.valid | insn_ready;

    // Lowest-index pending key wins; its bit is released only when the register loads
    always_comb begin
        clr      = '0;
        found    = 1'b0;
        slot_nxt = '{valid: 1'b0, insn: NOP};
        for (int i = 0; i < N_KEYS; i++) begin
            if (pend[i] && !found) begin
                found    = 1'b1;
                clr[i]   = load;
                slot_nxt = '{valid: 1'b1, insn: insn_table[i*INSN_W +: INSN_W]};
            end
        end
    end

    // Pending bits: a new event beats a same-cycle clear; a second event while pending is lost
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pend    <= '0;
            dropped <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | ev;
            if (|(ev & pend & ~clr)) dropped <= 1'b1;
        end
    end

    // Output register holds steady while the processor stalls
    always_ff @(posedge clk_in) begin
        if (reset)     slot_q <= '{valid: 1'b0, insn: NOP};
        else if (load) slot_q <= slot_nxt;
    end

    assign insn_key   = slot_q.insn;
    assign insn_valid = slot_q.valid;
endmodule
